ps2_frame_rx: RTL and testbench

Parametrised receiver for PS/2-style 11-bit serial frames: start bit, DATA_W data bits LSB first, odd parity and stop bit. It runs entirely on the system clock and treats the raw device clock and data lines as asynchronous inputs. It checks parity, framing and inter-bit timeout, optionally absorbs E0/F0 scan-code prefixes, and presents each accepted byte on a held output with a one-cycle strobe. It sits between the keyboard pins and the scan-code consumer logic.

---
 rtl/ps2_frame_rx_pkg.sv | 16 +
 rtl/ps2_frame_rx_if.sv | 23 ++
 rtl/ps2_line_filter.sv | 52 +++++
 rtl/ps2_frame_rx.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_frame_rx.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_frame_rx_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_REL = 8'hF0;

  localparam int unsigned TIMEOUT_CYC_DEF = 10000;

endpackage

// File: rtl/ps2_frame_rx_if.sv
// Pin-side inputs and decoded outputs of the PS/2 frame receiver.
interface ps2_frame_rx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              ps2_clk;
  logic              ps2_data;
  logic [DATA_W-1:0] code;
  logic              new_code;
  logic              ext;
  logic              rel;
  logic              par_err;
  logic              frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  code, new_code, ext, rel, par_err, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output code, new_code, ext, rel, par_err, frame_err
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Synchroniser, run-length glitch filter and registered falling-edge pulse
// for one asynchronous PS/2 line.
module ps2_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          run_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // The level flips only after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      run_q <= '0;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (synced != level) begin
        if (run_q == CW'(FILT_LEN - 1)) begin
          level <= synced;
          run_q <= '0;
          fall  <= ~synced;
        end else begin
          run_q <= run_q + 1'b1;
        end
      end else begin
        run_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 11-bit frame receiver: parity, framing and timeout checks.
// Optional E0/F0 prefix absorption when PS2_RX_PREFIX_DECODE_EN is defined.
module ps2_frame_rx
  import ps2_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic           clk,
  input logic           rst_n,
  ps2_frame_rx_if.slave bus
);

  localparam int unsigned BW = $clog2(DATA_W + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  logic clk_fall;
  logic data_lvl;

  ps2_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_clk_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.ps2_clk),
    .level (),
    .fall  (clk_fall)
  );

  ps2_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (1)
  ) u_data_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.ps2_data),
    .level (data_lvl),
    .fall  ()
  );

  rx_state_e         state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [DATA_W-1:0] code_q, code_d;
  logic              new_code_q, new_code_d;
  logic              par_err_q, par_err_d;
  logic              frame_err_q, frame_err_d;
  logic              tmo_expired;

`ifdef PS2_RX_PREFIX_DECODE_EN
  localparam bit PREFIX_OK = (DATA_W == 8);

  logic ext_q, ext_d;
  logic rel_q, rel_d;
  logic ext_pend_q, ext_pend_d;
  logic rel_pend_q, rel_pend_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      ext_pend_q <= 1'b0;
      rel_pend_q <= 1'b0;
    end else begin
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      ext_pend_q <= ext_pend_d;
      rel_pend_q <= rel_pend_d;
    end
  end

  assign bus.ext = ext_q;
  assign bus.rel = rel_q;
`else
  assign bus.ext = 1'b0;
  assign bus.rel = 1'b0;
`endif

  assign tmo_expired = (state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      code_q      <= '0;
      new_code_q  <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      code_q      <= code_d;
      new_code_q  <= new_code_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    code_d      = code_q;
    new_code_d  = 1'b0;
    par_err_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef PS2_RX_PREFIX_DECODE_EN
    ext_d       = ext_q;
    rel_d       = rel_q;
    ext_pend_d  = ext_pend_q;
    rel_pend_d  = rel_pend_q;
`endif

    if (state_q == ST_IDLE || clk_fall) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    // Expiry takes priority over a coincident bit event.
    if (tmo_expired) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      tmo_d       = '0;
    end else if (clk_fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_lvl) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d = {data_lvl, shreg_q[DATA_W-1:1]};
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          par_d   = data_lvl;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!data_lvl) begin
            frame_err_d = 1'b1;
          end else if (^{shreg_q, par_q} == 1'b0) begin
            par_err_d = 1'b1;
          end else begin
`ifdef PS2_RX_PREFIX_DECODE_EN
            if (PREFIX_OK && shreg_q == DATA_W'(PREFIX_EXT)) begin
              ext_pend_d = 1'b1;
            end else if (PREFIX_OK && shreg_q == DATA_W'(PREFIX_REL)) begin
              rel_pend_d = 1'b1;
            end else begin
              new_code_d = 1'b1;
              code_d     = shreg_q;
              ext_d      = ext_pend_q;
              rel_d      = rel_pend_q;
              ext_pend_d = 1'b0;
              rel_pend_d = 1'b0;
            end
`else
            new_code_d = 1'b1;
            code_d     = shreg_q;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

`ifdef PS2_RX_PREFIX_DECODE_EN
    if (frame_err_d || par_err_d) begin
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
    end
`endif
  end

  assign bus.code      = code_q;
  assign bus.new_code  = new_code_q;
  assign bus.par_err   = par_err_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx; expectations follow PS2_RX_PREFIX_DECODE_EN.
module tb_ps2_frame_rx;
  import ps2_rx_pkg::*;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TMO    = 1000;
  localparam int unsigned HALF   = 20;

  typedef struct {
    logic [2:0] kind;   // {new_code, par_err, frame_err}
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ps2_frame_rx_if #(.DATA_W(DATA_W)) bus ();

  ps2_frame_rx #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (2),
    .FILT_LEN    (4),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] m_code   = '0;
  logic       m_ext    = 1'b0;
  logic       m_rel    = 1'b0;
  logic       m_ext_p  = 1'b0;
  logic       m_rel_p  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par_flip,
                                             input logic stop);
    return {stop, (~^d) ^ par_flip, d, 1'b0};
  endfunction

  task automatic push_good(input logic [7:0] d);
`ifdef PS2_RX_PREFIX_DECODE_EN
    if (d == 8'hE0) begin
      m_ext_p = 1'b1;
    end else if (d == 8'hF0) begin
      m_rel_p = 1'b1;
    end else begin
      m_code  = d;
      m_ext   = m_ext_p;
      m_rel   = m_rel_p;
      m_ext_p = 1'b0;
      m_rel_p = 1'b0;
      exp_q.push_back('{3'b100, m_code, m_ext, m_rel});
    end
`else
    m_code = d;
    exp_q.push_back('{3'b100, m_code, 1'b0, 1'b0});
`endif
  endtask

  task automatic push_err(input logic [2:0] kind);
    m_ext_p = 1'b0;
    m_rel_p = 1'b0;
    exp_q.push_back('{kind, m_code, m_ext, m_rel});
  endtask

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    cycles(HALF);
    bus.ps2_clk = 1'b0;
    cycles(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_raw(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) ps2_bit(fr[i]);
    cycles(HALF);
    bus.ps2_data = 1'b1;
    cycles(2 * HALF);
  endtask

  task automatic send_good(input logic [7:0] d);
    push_good(d);
    send_raw(make_frame(d, 1'b0, 1'b1), 11);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) cycles(1);
    cycles(20);
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_code"}, bus.code, 0);
    check({tag, "_new_code"}, bus.new_code, 0);
    check({tag, "_ext"}, bus.ext, 0);
    check({tag, "_rel"}, bus.rel, 0);
    check({tag, "_par_err"}, bus.par_err, 0);
    check({tag, "_frame_err"}, bus.frame_err, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && {bus.new_code, bus.par_err, bus.frame_err} != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("spurious_strobe", {bus.new_code, bus.par_err, bus.frame_err}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind", {bus.new_code, bus.par_err, bus.frame_err}, mon_e.kind);
        check("code", bus.code, mon_e.code);
        check("ext", bus.ext, mon_e.ext);
        check("rel", bus.rel, mon_e.rel);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    cycles(5);
    check_zero("reset");
    rst_n = 1'b1;
    cycles(20);

    // Good 0x1C, then bad parity, then bad stop followed by good 0x32.
    send_good(8'h1C);
    drain("drain_good");
    push_err(3'b010);
    send_raw(make_frame(8'h1C, 1'b1, 1'b1), 11);
    drain("drain_parity");
    push_err(3'b001);
    send_raw(make_frame(8'h1C, 1'b0, 1'b0), 11);
    send_good(8'h32);
    drain("drain_stop");

    // Device clock stalls after 4 data bits.
    push_err(3'b001);
    send_raw(make_frame(8'hA5, 1'b0, 1'b1), 5);
    drain("drain_timeout");
    send_good(8'h5A);
    drain("drain_after_timeout");

    // Prefix sequence E0 F0 75 then plain 75.
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    send_good(8'h75);
    drain("drain_prefix");

    // Short low glitches with data low must not start a frame.
    bus.ps2_data = 1'b0;
    for (int g = 0; g < 3; g++) begin
      bus.ps2_clk = 1'b0;
      cycles(3);
      bus.ps2_clk = 1'b1;
      cycles(10);
    end
    bus.ps2_data = 1'b1;
    cycles(20);
    send_good(8'h1C);
    drain("drain_glitch");

    // Reset after 5 data bits of a frame.
    send_raw(make_frame(8'h6B, 1'b0, 1'b1), 6);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    m_code  = '0;
    m_ext   = 1'b0;
    m_rel   = 1'b0;
    m_ext_p = 1'b0;
    m_rel_p = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(50);
    send_good(8'h32);
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
